// File: rtl/armleocpu_defs.sv
`default_nettype none
// ============================================================================
//  Module   : armleocpu_defs (package)
//  Brief    : Shared bus command/response codes and memory arbiter state
//             encoding for the ArmleoCPU memory subsystem.
//  Revision : 1.0 - initial release
// ============================================================================
package armleocpu_defs;

  // Bus command codes
  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_READ  = 3'd1;
  localparam logic [2:0] CMD_WRITE = 3'd2;

  // Bus response codes
  localparam logic [2:0] RESP_OK    = 3'd0;
  localparam logic [2:0] RESP_ERROR = 3'd1;

  // Arbiter states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_D = 2'd1,
    GRANT_I = 2'd2
  } arb_state_t;

  // Index of the final beat of a burst; a burstcount of 0 means one beat.
  function automatic logic [3:0] burst_last(input logic [3:0] burstcount);
    burst_last = (burstcount == 4'd0) ? 4'd0 : burstcount - 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/armleocpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : armleocpu_mem_arbiter
//  Brief    : Two-master (D-cache, I-cache) to one-slave memory arbiter.
//             Round-robin grant per whole burst; the winning master's
//             response channel is passed through combinationally.
//  Revision : 1.0 - initial release
// ============================================================================
module armleocpu_mem_arbiter
  import armleocpu_defs::*;
#(
  parameter int ADDR_WIDTH = 34,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    d_transaction,
  input  logic [2:0]              d_cmd,
  input  logic [ADDR_WIDTH-1:0]   d_address,
  input  logic [3:0]              d_burstcount,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wbyte_enable,
  output logic                    d_transaction_done,
  output logic [2:0]              d_transaction_response,
  output logic [DATA_WIDTH-1:0]   d_rdata,

  input  logic                    i_transaction,
  input  logic [2:0]              i_cmd,
  input  logic [ADDR_WIDTH-1:0]   i_address,
  input  logic [3:0]              i_burstcount,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wbyte_enable,
  output logic                    i_transaction_done,
  output logic [2:0]              i_transaction_response,
  output logic [DATA_WIDTH-1:0]   i_rdata,

  output logic                    m_transaction,
  output logic [2:0]              m_cmd,
  output logic [ADDR_WIDTH-1:0]   m_address,
  output logic [3:0]              m_burstcount,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wbyte_enable,
  input  logic                    m_transaction_done,
  input  logic [2:0]              m_transaction_response,
  input  logic [DATA_WIDTH-1:0]   m_rdata
);

  arb_state_t state, next_state;
  logic       last_grant_i;   // 1: last burst went to I, 0: to D
  logic [3:0] beat_cnt;
  logic       sel_transaction;
  logic [3:0] sel_burstcount;
  logic       burst_end;

  // Request fields of whichever master currently holds the grant
  always_comb begin
    sel_transaction = 1'b0;
    sel_burstcount  = 4'd0;
    if (state == GRANT_D) begin
      sel_transaction = d_transaction;
      sel_burstcount  = d_burstcount;
    end else if (state == GRANT_I) begin
      sel_transaction = i_transaction;
      sel_burstcount  = i_burstcount;
    end
  end

  // Last beat reached, or early termination on an error response
  assign burst_end = m_transaction_done &&
                     ((beat_cnt == burst_last(sel_burstcount)) ||
                      (m_transaction_response != RESP_OK));

  // State, round-robin pointer and beat counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant_i <= 1'b1;
      beat_cnt     <= 4'd0;
    end else begin
      state <= next_state;
      if (state == IDLE) begin
        beat_cnt <= 4'd0;
        if (next_state == GRANT_D) last_grant_i <= 1'b0;
        if (next_state == GRANT_I) last_grant_i <= 1'b1;
      end else if (m_transaction_done) begin
        beat_cnt <= beat_cnt + 4'd1;
      end
    end
  end

  // Next-state: round-robin arbitration in IDLE, burst tracking in grants
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (d_transaction && i_transaction)
          next_state = last_grant_i ? GRANT_D : GRANT_I;
        else if (d_transaction)
          next_state = GRANT_D;
        else if (i_transaction)
          next_state = GRANT_I;
      end
      GRANT_D, GRANT_I: begin
        // A master dropping its request mid-burst aborts the grant
        if (!sel_transaction || burst_end)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request mux toward the slave and response steering to the masters
  always_comb begin
    m_transaction          = 1'b0;
    m_cmd                  = CMD_NONE;
    m_address              = '0;
    m_burstcount           = 4'd0;
    m_wdata                = '0;
    m_wbyte_enable         = '0;
    d_transaction_done     = 1'b0;
    d_transaction_response = 3'd0;
    d_rdata                = '0;
    i_transaction_done     = 1'b0;
    i_transaction_response = 3'd0;
    i_rdata                = '0;
    if (state == GRANT_D) begin
      m_transaction          = d_transaction;
      m_cmd                  = d_cmd;
      m_address              = d_address;
      m_burstcount           = d_burstcount;
      m_wdata                = d_wdata;
      m_wbyte_enable         = d_wbyte_enable;
      d_transaction_done     = m_transaction_done;
      d_transaction_response = m_transaction_response;
      d_rdata                = m_rdata;
    end else if (state == GRANT_I) begin
      m_transaction          = i_transaction;
      m_cmd                  = i_cmd;
      m_address              = i_address;
      m_burstcount           = i_burstcount;
      m_wdata                = i_wdata;
      m_wbyte_enable         = i_wbyte_enable;
      i_transaction_done     = m_transaction_done;
      i_transaction_response = m_transaction_response;
      i_rdata                = m_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_armleocpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_armleocpu_mem_arbiter
//  Brief    : Scoreboard bench for the two-master memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_armleocpu_mem_arbiter;
  import armleocpu_defs::*;

  localparam int AW = 34;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          d_transaction = 1'b0, i_transaction = 1'b0;
  logic [2:0]    d_cmd = CMD_NONE, i_cmd = CMD_NONE;
  logic [AW-1:0] d_address = '0, i_address = '0;
  logic [3:0]    d_burstcount = 4'd0, i_burstcount = 4'd0;
  logic [DW-1:0] d_wdata = '0, i_wdata = '0;
  logic [3:0]    d_wbyte_enable = 4'd0, i_wbyte_enable = 4'd0;
  logic          d_transaction_done, i_transaction_done;
  logic [2:0]    d_transaction_response, i_transaction_response;
  logic [DW-1:0] d_rdata, i_rdata;
  logic          m_transaction;
  logic [2:0]    m_cmd;
  logic [AW-1:0] m_address;
  logic [3:0]    m_burstcount;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_wbyte_enable;
  logic          m_transaction_done = 1'b0;
  logic [2:0]    m_transaction_response = RESP_OK;
  logic [DW-1:0] m_rdata = '0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0]    who;   // {d, i}
    logic [DW-1:0] rdata;
    logic [2:0]    resp;
  } exp_t;
  exp_t exp_q[$];

  localparam logic [AW-1:0] D_ADDR = 34'h2_0000_1000;
  localparam logic [AW-1:0] I_ADDR = 34'h1_0000_0200;

  armleocpu_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_transaction(d_transaction), .d_cmd(d_cmd), .d_address(d_address),
    .d_burstcount(d_burstcount), .d_wdata(d_wdata), .d_wbyte_enable(d_wbyte_enable),
    .d_transaction_done(d_transaction_done), .d_transaction_response(d_transaction_response),
    .d_rdata(d_rdata),
    .i_transaction(i_transaction), .i_cmd(i_cmd), .i_address(i_address),
    .i_burstcount(i_burstcount), .i_wdata(i_wdata), .i_wbyte_enable(i_wbyte_enable),
    .i_transaction_done(i_transaction_done), .i_transaction_response(i_transaction_response),
    .i_rdata(i_rdata),
    .m_transaction(m_transaction), .m_cmd(m_cmd), .m_address(m_address),
    .m_burstcount(m_burstcount), .m_wdata(m_wdata), .m_wbyte_enable(m_wbyte_enable),
    .m_transaction_done(m_transaction_done), .m_transaction_response(m_transaction_response),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Slave returns one beat; the expected delivery is queued for the monitor
  task automatic beat(input logic [1:0] who, input logic [DW-1:0] data, input logic [2:0] resp);
    exp_t e;
    e.who = who; e.rdata = data; e.resp = resp;
    exp_q.push_back(e);
    m_transaction_done     = 1'b1;
    m_rdata                = data;
    m_transaction_response = resp;
    tick();
    m_transaction_done     = 1'b0;
    m_rdata                = '0;
    m_transaction_response = RESP_OK;
  endtask

  // Monitor: every done pulse seen by a master must match the scoreboard head
  always @(negedge clk) begin
    if (rst_n && (d_transaction_done || i_transaction_done)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {62'd0, d_transaction_done, i_transaction_done}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_route", {62'd0, d_transaction_done, i_transaction_done}, {62'd0, e.who});
        check("d_rdata", {32'd0, d_rdata}, {32'd0, (e.who[1] ? e.rdata : 32'd0)});
        check("i_rdata", {32'd0, i_rdata}, {32'd0, (e.who[0] ? e.rdata : 32'd0)});
        check("resp", {61'd0, (e.who[1] ? d_transaction_response : i_transaction_response)},
              {61'd0, e.resp});
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    #7;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    d_cmd = CMD_READ; d_address = D_ADDR;
    i_cmd = CMD_READ; i_address = I_ADDR;
    do_reset();

    // Reset state of the slave-side request
    check("rst_m_transaction", {63'd0, m_transaction}, 64'd0);
    check("rst_m_cmd", {61'd0, m_cmd}, {61'd0, CMD_NONE});
    check("rst_m_address", {30'd0, m_address}, 64'd0);

    // ---- Single D read, burst of 4 ----
    d_burstcount = 4'd4; d_transaction = 1'b1;
    #1 check("t1_not_yet_granted", {63'd0, m_transaction}, 64'd0);
    tick();
    check("t1_granted", {63'd0, m_transaction}, 64'd1);
    check("t1_m_address", {30'd0, m_address}, {30'd0, D_ADDR});
    check("t1_m_burstcount", {60'd0, m_burstcount}, 64'd4);
    for (int b = 0; b < 4; b++) beat(2'b10, 32'hA000_0000 + b, RESP_OK);
    check("t1_idle_after_4", {63'd0, m_transaction}, 64'd0);
    d_transaction = 1'b0;
    tick();
    check("t1_stays_idle", {63'd0, m_transaction}, 64'd0);

    // ---- Simultaneous D and I after reset: D, I, D ----
    do_reset();
    d_burstcount = 4'd2; i_burstcount = 4'd2;
    d_transaction = 1'b1; i_transaction = 1'b1;
    tick();
    check("t2_first_d", {30'd0, m_address}, {30'd0, D_ADDR});
    beat(2'b10, 32'h1111_0001, RESP_OK);
    beat(2'b10, 32'h1111_0002, RESP_OK);
    check("t2_gap_after_d", {63'd0, m_transaction}, 64'd0);
    tick();
    check("t2_then_i", {30'd0, m_address}, {30'd0, I_ADDR});
    check("t2_i_txn", {63'd0, m_transaction}, 64'd1);
    beat(2'b01, 32'h2222_0001, RESP_OK);
    beat(2'b01, 32'h2222_0002, RESP_OK);
    check("t2_gap_after_i", {63'd0, m_transaction}, 64'd0);
    tick();
    check("t2_then_d_again", {30'd0, m_address}, {30'd0, D_ADDR});
    beat(2'b10, 32'h1111_0003, RESP_OK);
    beat(2'b10, 32'h1111_0004, RESP_OK);
    d_transaction = 1'b0; i_transaction = 1'b0;
    tick();

    // ---- I read of 8 terminated by error on beat 3, D write bc=0 pending ----
    i_burstcount = 4'd8; i_transaction = 1'b1;
    tick();
    check("t3_i_granted", {30'd0, m_address}, {30'd0, I_ADDR});
    d_cmd = CMD_WRITE; d_burstcount = 4'd0; d_wdata = 32'hDEAD_BEEF;
    d_wbyte_enable = 4'b1111; d_transaction = 1'b1;
    beat(2'b01, 32'h3333_0001, RESP_OK);
    beat(2'b01, 32'h3333_0002, RESP_OK);
    beat(2'b01, 32'h3333_0003, RESP_ERROR);
    check("t3_idle_after_error", {63'd0, m_transaction}, 64'd0);
    i_transaction = 1'b0;
    tick();
    check("t4_d_granted", {30'd0, m_address}, {30'd0, D_ADDR});
    check("t4_m_cmd", {61'd0, m_cmd}, {61'd0, CMD_WRITE});
    check("t4_m_wdata", {32'd0, m_wdata}, 64'hDEAD_BEEF);
    check("t4_m_wbe", {60'd0, m_wbyte_enable}, 64'hF);
    beat(2'b10, 32'h0, RESP_OK);
    check("t4_single_beat_done", {63'd0, m_transaction}, 64'd0);
    d_transaction = 1'b0; d_cmd = CMD_READ; d_wdata = '0; d_wbyte_enable = 4'd0;
    tick();

    // ---- Reset asserted at beat 2 of 4 ----
    d_burstcount = 4'd4; d_transaction = 1'b1;
    tick();
    check("t5_granted", {63'd0, m_transaction}, 64'd1);
    beat(2'b10, 32'h5555_0001, RESP_OK);
    beat(2'b10, 32'h5555_0002, RESP_OK);
    #2 rst_n = 1'b0;
    #1 check("t5_async_drop", {63'd0, m_transaction}, 64'd0);
    check("t5_async_cmd", {61'd0, m_cmd}, {61'd0, CMD_NONE});
    #3 rst_n = 1'b1;
    tick();
    check("t5_regrant", {63'd0, m_transaction}, 64'd1);
    for (int b = 0; b < 3; b++) beat(2'b10, 32'h6666_0000 + b, RESP_OK);
    check("t5_fresh_count_not_ended", {63'd0, m_transaction}, 64'd1);
    beat(2'b10, 32'h6666_0003, RESP_OK);
    check("t5_fresh_count_ended", {63'd0, m_transaction}, 64'd0);
    d_transaction = 1'b0;
    tick();

    // ---- Granted master abandons its burst after 1 of 4 beats ----
    d_transaction = 1'b1;
    tick();
    beat(2'b10, 32'h7777_0001, RESP_OK);
    d_transaction = 1'b0;
    tick();
    check("t6_idle_after_drop", {61'd0, dut.state}, {61'd0, IDLE});
    m_transaction_done = 1'b1; m_rdata = 32'hBAD0_0000;
    #1 check("t6_stray_no_d_done", {63'd0, d_transaction_done}, 64'd0);
    check("t6_stray_no_i_done", {63'd0, i_transaction_done}, 64'd0);
    tick();
    m_transaction_done = 1'b0; m_rdata = '0;
    check("t6_still_idle", {63'd0, m_transaction}, 64'd0);
    tick();

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
